// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_pkg : shared types and constants for the instruction fetch unit
// Rev 1.0
// ============================================================================
package instr_fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : power-of-two FIFO with flush; push+pop on a full FIFO is legal
// Rev 1.0
// ============================================================================
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = 2 * INSTR_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : credit-limited instruction fetcher with redirect flush
// Rev 1.0
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int ENTRY_W = 2 * INSTR_W;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int SW      = CW + 1;
    localparam logic [SW-1:0] DEPTH_LIM = SW'(FIFO_DEPTH);

    fetch_state_t       r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_addr;
    logic               r_outstanding;
    logic               r_discard;

    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic [SW-1:0]      w_used;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_bits;

    // buffered plus in-flight words may never exceed the buffer size
    assign w_used    = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding};
    assign imem_req  = (r_state == RUN) && (w_used < DEPTH_LIM) && !redirect_valid;
    assign imem_addr = r_fetch_pc;
    assign w_accept  = imem_req && imem_gnt;
    assign w_push    = imem_rvalid && r_outstanding && !r_discard;
    assign w_pop     = !w_empty && instr_ready && !redirect_valid;

    assign instr_valid   = !w_empty;
    assign instruction   = w_empty ? '0 : w_head[ENTRY_W-1:INSTR_W];
    assign instr_pc      = w_empty ? '0 : w_head[INSTR_W-1:0];
    assign w_unused_bits = ^{redirect_pc[1:0], w_full};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_discard <= redirect_valid;
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     if (redirect_valid) r_state <= FLUSH;
                FLUSH:   if (!redirect_valid) r_state <= RUN;
                default: r_state <= IDLE;
            endcase
            if (redirect_valid) begin
                r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
                r_outstanding <= 1'b0;
            end else if (w_accept) begin
                r_fetch_pc    <= r_fetch_pc + PC_INC;
                r_req_addr    <= r_fetch_pc;
                r_outstanding <= 1'b1;
            end else if (imem_rvalid) begin
                r_outstanding <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (w_push),
        .push_data ({imem_rdata, r_req_addr}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed scenarios plus random traffic against a stream model
// Rev 1.0
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    int checks    = 0;
    int fails     = 0;
    int grant_cnt = 0;
    int delivered = 0;

    instr_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!instr_valid && i < 20) begin
            edge_();
            mid();
            i++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    // memory: answers every accepted request exactly one cycle later
    initial begin : memory
        bit          acc;
        logic [31:0] acc_addr;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_gnt && reset;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = acc;
            imem_rdata  = acc ? mem_word(acc_addr) : 32'hDEAD_BEEF;
            if (acc) grant_cnt++;
        end
    end

    // stream model: delivered PCs run sequentially from the last redirect target
    initial begin : monitor
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_wait;
        bit          prev_redir;
        int          occ;
        exp_pc     = RESET_PC;
        prev_addr  = '0;
        prev_wait  = 1'b0;
        prev_redir = 1'b0;
        occ        = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_pc     = RESET_PC;
                prev_wait  = 1'b0;
                prev_redir = 1'b0;
                occ        = 0;
            end else begin
                if (prev_redir) chk("valid_after_redirect", 32'(instr_valid), 32'd0);
                if (prev_wait && !redirect_valid) begin
                    chk("req_hold", 32'(imem_req), 32'd1);
                    chk("addr_hold", imem_addr, prev_addr);
                end
                chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
                if (redirect_valid) begin
                    chk("req_in_redirect", 32'(imem_req), 32'd0);
                    exp_pc = {redirect_pc[31:2], 2'b00};
                    occ    = 0;
                end else begin
                    if (imem_req && imem_gnt) occ++;
                    if (instr_valid && instr_ready) begin
                        chk("stream_pc", instr_pc, exp_pc);
                        chk("stream_word", instruction, mem_word(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        occ--;
                        delivered++;
                    end
                    chk("credit", 32'(occ >= 0 && occ <= DEPTH), 32'd1);
                end
                prev_redir = redirect_valid;
                prev_wait  = imem_req && !imem_gnt;
                prev_addr  = imem_addr;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int g0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);

        // first fetches with the grant tied high and the consumer stalled
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        imem_gnt = 1'b1;
        mid();
        chk("idle_req", 32'(imem_req), 32'd0);
        edge_(); mid();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        edge_(); mid();
        chk("second_addr", imem_addr, 32'h4);
        edge_(); mid();
        chk("third_addr", imem_addr, 32'h8);
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_pc", instr_pc, 32'h0);
        chk("first_word", instruction, mem_word(32'h0));

        // buffer fills to DEPTH, then one pop releases exactly one request
        edge_(); mid();
        edge_(); mid();
        chk("full_req_low", 32'(imem_req), 32'd0);
        edge_(); mid();
        chk("full_req_low2", 32'(imem_req), 32'd0);
        chk("full_grants", 32'(grant_cnt), 32'd4);
        edge_();
        instr_ready = 1'b1;
        mid();
        edge_();
        instr_ready = 1'b0;
        g0 = grant_cnt;
        repeat (5) begin
            edge_(); mid();
        end
        chk("one_refill", 32'(grant_cnt - g0), 32'd1);
        chk("refill_req_low", 32'(imem_req), 32'd0);
        chk("refill_valid", 32'(instr_valid), 32'd1);

        // asynchronous reset with a full buffer
        edge_();
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, RESET_PC);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instruction, 32'd0);
        chk("mid_rst_pc", instr_pc, 32'd0);
        mid();
        edge_();
        reset       = 1'b1;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        mid();
        edge_(); mid();
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, RESET_PC);
        edge_(); mid();
        chk("restart_addr4", imem_addr, 32'h4);

        // grant withheld for three cycles while 0x8 is requested
        edge_();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_req", 32'(imem_req), 32'd1);
            if (i == 2) chk("stall_no_push", 32'(instr_valid), 32'd0);
            edge_();
        end
        imem_gnt = 1'b1;
        mid();
        chk("stall_release_addr", imem_addr, 32'h8);
        edge_(); mid();
        chk("after_stall_addr", imem_addr, 32'hC);

        // redirect with a response in flight, coinciding with a ready consumer
        edge_();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        mid();
        chk("redir_req", 32'(imem_req), 32'd0);
        edge_();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        mid();
        chk("redir_valid_low", 32'(instr_valid), 32'd0);
        wait_valid("redir_wait");
        chk("redir_pc", instr_pc, 32'h0000_0100);
        chk("redir_word", instruction, mem_word(32'h0000_0100));

        // unaligned redirect near the top of the address space wraps to zero
        edge_();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        instr_ready    = 1'b1;
        mid();
        edge_();
        redirect_valid = 1'b0;
        mid();
        wait_valid("wrap_wait1");
        chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
        edge_(); mid();
        wait_valid("wrap_wait2");
        chk("wrap_pc_zero", instr_pc, 32'h0000_0000);

        // random traffic, checked by the stream model
        for (int n = 0; n < 800; n++) begin
            edge_();
            imem_gnt       = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            mid();
        end
        edge_();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        instr_ready    = 1'b0;
        mid();
        chk("random_progress", 32'(delivered > 100), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the instruction buffer entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: memory accepts request this cycle.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: read data valid, exactly one cycle after a grant.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: new fetch address; bits [1:0] ignored.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instruction available to processor.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: processor consumes instruction this cycle.
REQ-014 The block SHALL have port instruction, output, 32 bits: head-of-buffer instruction word.
REQ-015 The block SHALL have port instr_pc, output, 32 bits: address of the instruction presented.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and FLUSH; IDLE->RUN one cycle after reset deasserts; RUN->FLUSH on redirect_valid; FLUSH->RUN after exactly one cycle, or stays FLUSH if redirect_valid is asserted again.
REQ-017 imem_req SHALL be asserted only in RUN, and only when (buffer count + outstanding) < FIFO_DEPTH and redirect_valid is low.
REQ-018 A request SHALL be accepted when imem_req and imem_gnt are both high; fetch PC then increments by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 imem_addr and imem_req SHALL hold stable while imem_gnt is low.
REQ-020 An accepted request SHALL set outstanding=1, and the matching imem_rvalid SHALL push {imem_rdata, request address} into the buffer unless discarded.
REQ-021 On redirect_valid the buffer SHALL be flushed, fetch PC loaded with {redirect_pc[31:2],2'b00}, and any response arriving in the next cycle discarded.
REQ-022 The buffer SHALL be a FIFO: instr_valid = not empty; pop when instr_valid && instr_ready; simultaneous push and pop SHALL keep count unchanged, including when full.
REQ-023 The block SHALL never overflow (credit rule REQ-017) and pop from empty SHALL have no effect.
REQ-024 redirect_valid and instr_ready in the same cycle SHALL resolve as flush (pop ignored); instr_valid SHALL be low the cycle after a redirect.
REQ-025 Fetch-to-instr_valid latency SHALL be 2 cycles from grant (1 cycle memory + 1 cycle buffer write) when the buffer is empty.

Reset
REQ-026 When reset is low: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, FSM=IDLE, count=0, outstanding=0.
REQ-027 Reset asserted mid-operation SHALL abort all in-flight state, and an imem_rvalid in the first cycle after release SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the INSTR_W=32 constant and the PC increment constant 4.
REQ-029 The buffer SHALL be one sub-module, fetch_fifo (parameterised width/depth, push/pop/flush, full/empty/count).

Verification
REQ-030 Reset release, imem_gnt tied high, rdata=addr-derived: first imem_addr=0x0, then 0x4, 0x8; instr_valid high 2 cycles after first grant with instr_pc=0x0.
REQ-031 instr_ready=0 with gnt=1: exactly FIFO_DEPTH=4 instructions buffered, imem_req then low; a single ready pulse -> exactly one new request.
REQ-032 Redirect to 0x100 with one response in flight: in-flight word dropped, instr_valid low next cycle, next instr_pc=0x100.
REQ-033 imem_gnt low for 3 cycles: imem_addr held at 0x8, no increment, no spurious rvalid push.
REQ-034 redirect_pc=0xFFFF_FFFE: fetches 0xFFFF_FFFC then wraps to 0x0000_0000.
REQ-035 reset pulsed low mid-stream with buffer full: all outputs at reset values, fetch restarts at RESET_PC.
